// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM sequencing fetch/decode/execute/memory/write-back.
//   in : Clk, Reset (sync, active-high), Opcode/Funct (from IR), Zero (ALU flag), MemAck
//   out: PC_LdEn/PC_sel, IR_LdEn, RF_WrEn/RF_WrDst_sel/RF_WrData_sel, ALU_Bin_sel, Imm_zext,
//        ALU_func, MEM_RdEn/MEM_WrEn, Illegal pulse, Retired count, State (debug)
module mc_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemAck,
    output logic        PC_LdEn,
    output logic [1:0]  PC_sel,
    output logic        IR_LdEn,
    output logic        RF_WrEn,
    output logic        RF_WrDst_sel,
    output logic        RF_WrData_sel,
    output logic        ALU_Bin_sel,
    output logic        Imm_zext,
    output logic [3:0]  ALU_func,
    output logic        MEM_RdEn,
    output logic        MEM_WrEn,
    output logic        Illegal,
    output logic [31:0] Retired,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
        MEM_ADDR = 4'd4, MEM_RD = 4'd5, MEM_WR = 4'd6, WB_R = 4'd7,
        WB_I = 4'd8, WB_LW = 4'd9, BRANCH = 4'd10, JUMP = 4'd11
    } state_t;
    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        is_r, r_ok, is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j;
    logic [3:0]  r_func, i_func;
    always_comb begin
        is_r    = Opcode == 6'b000000;
        is_addi = Opcode == 6'b001000;
        is_andi = Opcode == 6'b001100;
        is_ori  = Opcode == 6'b001101;
        is_lw   = Opcode == 6'b100011;
        is_sw   = Opcode == 6'b101011;
        is_beq  = Opcode == 6'b000100;
        is_bne  = Opcode == 6'b000101;
        is_j    = Opcode == 6'b000010;
        r_func  = Funct == 6'b100010 ? 4'd1 :
                  Funct == 6'b100100 ? 4'd2 :
                  Funct == 6'b100101 ? 4'd3 :
                  Funct == 6'b101010 ? 4'd4 : 4'd0;
        r_ok    = is_r && (Funct == 6'b100000 || Funct == 6'b100010 || Funct == 6'b100100 ||
                           Funct == 6'b100101 || Funct == 6'b101010);
        i_func  = is_andi ? 4'd2 : is_ori ? 4'd3 : 4'd0;
    end
    always_comb begin
        state_d       = FETCH;
        PC_LdEn       = 1'b0;
        PC_sel        = 2'd0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrDst_sel  = 1'b0;
        RF_WrData_sel = 1'b0;
        ALU_Bin_sel   = 1'b0;
        Imm_zext      = 1'b0;
        ALU_func      = 4'd0;
        MEM_RdEn      = 1'b0;
        MEM_WrEn      = 1'b0;
        Illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                IR_LdEn = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = r_ok ? EXEC_R :
                          (is_addi || is_andi || is_ori) ? EXEC_I :
                          (is_lw || is_sw) ? MEM_ADDR :
                          (is_beq || is_bne) ? BRANCH :
                          is_j ? JUMP : FETCH;
                // Unsupported instructions retire here as a no-op advancing to PC+4.
                Illegal = state_d == FETCH;
                PC_LdEn = state_d == FETCH;
            end
            EXEC_R: begin
                ALU_func = r_func;
                state_d  = WB_R;
            end
            EXEC_I: begin
                ALU_Bin_sel = 1'b1;
                ALU_func    = i_func;
                Imm_zext    = is_andi || is_ori;
                state_d     = WB_I;
            end
            WB_R: begin
                ALU_func     = r_func;
                RF_WrEn      = 1'b1;
                RF_WrDst_sel = 1'b1;
                PC_LdEn      = 1'b1;
            end
            WB_I: begin
                ALU_Bin_sel = 1'b1;
                ALU_func    = i_func;
                Imm_zext    = is_andi || is_ori;
                RF_WrEn     = 1'b1;
                PC_LdEn     = 1'b1;
            end
            MEM_ADDR: begin
                ALU_Bin_sel = 1'b1;
                state_d     = is_lw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MEM_RdEn = 1'b1;
                state_d  = MemAck ? WB_LW : MEM_RD;
            end
            MEM_WR: begin
                MEM_WrEn = 1'b1;
                PC_LdEn  = MemAck;
                state_d  = MemAck ? FETCH : MEM_WR;
            end
            WB_LW: begin
                RF_WrEn       = 1'b1;
                RF_WrData_sel = 1'b1;
                PC_LdEn       = 1'b1;
            end
            BRANCH: begin
                ALU_func = 4'd1;
                PC_LdEn  = 1'b1;
                PC_sel   = ((is_beq && Zero) || (is_bne && !Zero)) ? 2'd1 : 2'd0;
            end
            JUMP: begin
                PC_LdEn = 1'b1;
                PC_sel  = 2'd2;
            end
            default: state_d = FETCH;
        endcase
        // Reset masks every side effect, even mid memory access.
        if (Reset) begin
            PC_LdEn  = 1'b0;
            IR_LdEn  = 1'b0;
            RF_WrEn  = 1'b0;
            MEM_RdEn = 1'b0;
            MEM_WrEn = 1'b0;
            Illegal  = 1'b0;
        end
        retired_d = retired_q + {31'd0, PC_LdEn};
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end
    assign Retired = retired_q;
    assign State   = state_q;
endmodule
